alu_req_arbiter: RTL

//  Shares one signed structural ALU between NUM_REQ requesters. Round-robin arbitration accepts
//  one operation at a time over a valid/ready handshake, drives A/B/ALU_FUNC into the ALU,

---
 rtl/alu_req_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_req_arbiter
//  Description : Round-robin front end that shares one registered ALU between
//                NUM_REQ requesters. One operation is in flight at a time:
//                accept -> wait out ALU latency -> hold response until taken.
//  Ports       : CLK/RST            clock, synchronous active-high reset
//                req_valid/ready    per-requester operation handshake
//                req_a/b/func       flattened per-requester operands/opcode
//                alu_a/b/func       registered drive into the ALU
//                alu_arith/logic/cmp/shift/flags   ALU result inputs
//                rsp_valid/ready    response handshake to owner rsp_id
//                rsp_data/flag      selected unit result and its flag
//                busy               high whenever the FSM is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter #(
    parameter int DATA_W  = 16,
    parameter int RES_W   = 32,
    parameter int NUM_REQ = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    input  logic [NUM_REQ*4-1:0]        req_func,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    output logic [3:0]                  alu_func,
    input  logic [RES_W-1:0]            alu_arith,
    input  logic [15:0]                 alu_logic,
    input  logic [1:0]                  alu_cmp,
    input  logic [16:0]                 alu_shift,
    input  logic [3:0]                  alu_flags,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [RES_W-1:0]            rsp_data,
    output logic                        rsp_flag,
    output logic                        busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_any;
    logic [ID_W-1:0]    w_grant;
    logic [ID_W-1:0]    w_next_ptr;
    logic               w_accept;
    logic [RES_W-1:0]   w_res;
    logic               w_flag;

    // Round-robin search: first pass covers rr_ptr..NUM_REQ-1, second pass
    // wraps to the indices below rr_ptr.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any && req_valid[i] && (ID_W'(i) >= r_rr_ptr)) begin
                w_any   = 1'b1;
                w_grant = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any && req_valid[i]) begin
                w_any   = 1'b1;
                w_grant = ID_W'(i);
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_any;
    assign w_next_ptr = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : (w_grant + ID_W'(1));

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // Unit select uses the opcode still held on alu_func. Flag bit order is
    // {Arith, Logic, CMP, SHIFT}.
    always_comb begin
        w_res  = '0;
        w_flag = 1'b0;
        case (alu_func[3:2])
            2'b00: begin
                w_res  = alu_arith;
                w_flag = alu_flags[3];
            end
            2'b01: begin
                w_res  = RES_W'(alu_logic);
                w_flag = alu_flags[2];
            end
            2'b10: begin
                w_res  = RES_W'(alu_cmp);
                w_flag = alu_flags[1];
            end
            default: begin
                w_res  = RES_W'(alu_shift);
                w_flag = alu_flags[0];
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_cnt     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_func  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_flag  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        alu_a    <= req_a[w_grant*DATA_W +: DATA_W];
                        alu_b    <= req_b[w_grant*DATA_W +: DATA_W];
                        alu_func <= req_func[w_grant*4 +: 4];
                        rsp_id   <= w_grant;
                        r_rr_ptr <= w_next_ptr;
                        r_cnt    <= CNT_W'(ALU_LAT);
                        busy     <= 1'b1;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // cnt reaching zero means the ALU output now reflects
                    // the latched operands.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        rsp_data  <= w_res;
                        rsp_flag  <= w_flag;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
